anneal_counter: RTL and testbench

Index and pseudo-temperature generator for the SSQA annealing core. It tracks three counts and one value: the multiply-accumulate index within a spin, the spin index within an iteration, the iteration count within a temperature step, and the signed pseudo-temperature Q. It is driven by the scheduler's en_mult / en_upd / rst_iter / rst_ini strobes and feeds count_mult, count_spin, count_comp and Q back to the scheduler. It also supplies the J-memory read address.

---
 rtl/anneal_counter_pkg.sv | 25 ++
 rtl/anneal_counter_if.sv | 39 +++
 rtl/anneal_counter_q_sat_step.sv | 16 +
 rtl/anneal_counter.sv | 103 ++++++++++
 tb/tb_anneal_counter.sv | 221 ++++++++++++++++++++++
 5 files changed

// File: rtl/anneal_counter_pkg.sv
// Shared SSQA definitions: scheduler state encoding, default sizes and the
// saturating Q step used by the counter and the temperature monitor.
package ssqa_pkg;

  localparam int SSQA_NN    = 800;
  localparam int SSQA_TEM_W = 8;
  localparam int SSQA_TAU_W = 8;

  typedef enum logic [3:0] {
    IDLE,
    INIT,
    MULT,
    UPD,
    IRESET,
    FIN
  } sched_state_t;

  // Operands arrive sign-extended to 32 bits, so the sum cannot wrap.
  function automatic int sat_add(input int q, input int step, input int qmax);
    int s;
    s = q + step;
    return (s > qmax) ? qmax : s;
  endfunction

endpackage

// File: rtl/anneal_counter_if.sv
// Strobe/feedback bundle between the SSQA scheduler (master) and the
// index/temperature counter (slave).
interface anneal_counter_if
  import ssqa_pkg::*;
#(
  parameter int NN        = SSQA_NN,
  parameter int TEM_WIDTH = SSQA_TEM_W,
  parameter int AW        = $clog2(NN * NN)
);
  localparam int CW = $clog2(NN);

  logic        [SSQA_TAU_W-1:0] tau;
  logic signed [TEM_WIDTH-1:0]  Qmin;
  logic signed [TEM_WIDTH-1:0]  Qmax;
  logic signed [TEM_WIDTH-1:0]  Qstep;
  logic                         en_mult;
  logic                         en_upd;
  logic                         rst_iter;
  logic                         rst_ini;

  logic        [CW-1:0]         count_mult;
  logic        [CW-1:0]         count_spin;
  logic        [SSQA_TAU_W-1:0] count_comp;
  logic signed [TEM_WIDTH-1:0]  Q;
  logic        [AW-1:0]         addr;
  logic                         q_step;
  logic                         iter_done;

  modport master (
    output tau, Qmin, Qmax, Qstep, en_mult, en_upd, rst_iter, rst_ini,
    input  count_mult, count_spin, count_comp, Q, addr, q_step, iter_done
  );

  modport slave (
    input  tau, Qmin, Qmax, Qstep, en_mult, en_upd, rst_iter, rst_ini,
    output count_mult, count_spin, count_comp, Q, addr, q_step, iter_done
  );

endinterface

// File: rtl/anneal_counter_q_sat_step.sv
// Combinational Q + Qstep clamped to Qmax; Qstep is non-negative so only
// the upper bound needs clamping.
module q_sat_step
  import ssqa_pkg::*;
#(
  parameter int TEM_WIDTH = SSQA_TEM_W
) (
  input  logic signed [TEM_WIDTH-1:0] i_q,
  input  logic signed [TEM_WIDTH-1:0] i_step,
  input  logic signed [TEM_WIDTH-1:0] i_qmax,
  output logic signed [TEM_WIDTH-1:0] o_q
);

  assign o_q = TEM_WIDTH'(sat_add(int'(i_q), int'(i_step), int'(i_qmax)));

endmodule

// File: rtl/anneal_counter.sv
// MAC/spin/iteration indices, J-memory address and pseudo-temperature Q for
// the SSQA core; sequencing is owned by the scheduler driving the strobes.
module anneal_counter
  import ssqa_pkg::*;
#(
  parameter int NN        = SSQA_NN,
  parameter int TEM_WIDTH = SSQA_TEM_W,
  parameter int AW        = $clog2(NN * NN)
) (
  input  logic             clk,
  input  logic             rst_sys,
  anneal_counter_if.slave  bus
);

  localparam int CW = $clog2(NN);
  localparam logic [CW-1:0] LAST_IDX  = CW'(NN - 1);
  localparam logic [AW-1:0] LAST_ADDR = AW'(NN * NN - 1);

  logic        [CW-1:0]         r_count_mult;
  logic        [CW-1:0]         r_count_spin;
  logic        [SSQA_TAU_W-1:0] r_count_comp;
  logic signed [TEM_WIDTH-1:0]  r_q;
  logic        [AW-1:0]         r_addr;
  logic                         r_q_step;
  logic                         r_iter_done;

  logic        [SSQA_TAU_W-1:0] w_comp_last;
  logic                         w_step_due;
  logic signed [TEM_WIDTH-1:0]  w_q_next;

  // tau == 0 is treated as one iteration per temperature step.
  assign w_comp_last = (bus.tau == '0) ? '0 : bus.tau - 1'b1;
  assign w_step_due  = (r_count_comp == w_comp_last);

  q_sat_step #(.TEM_WIDTH(TEM_WIDTH)) u_q_sat (
    .i_q   (r_q),
    .i_step(bus.Qstep),
    .i_qmax(bus.Qmax),
    .o_q   (w_q_next)
  );

  always_ff @(posedge clk or posedge rst_sys) begin
    if (rst_sys) begin
      r_count_mult <= '0;
      r_count_spin <= '0;
      r_count_comp <= '0;
      r_q          <= '0;
      r_addr       <= '0;
      r_q_step     <= 1'b0;
      r_iter_done  <= 1'b0;
    end else begin
      r_q_step    <= 1'b0;
      r_iter_done <= 1'b0;
      if (bus.rst_ini) begin
        r_count_mult <= '0;
        r_count_spin <= '0;
        r_count_comp <= '0;
        r_addr       <= '0;
        r_q          <= bus.Qmin;
      end else if (bus.rst_iter) begin
        r_count_mult <= '0;
        r_count_spin <= '0;
        r_addr       <= '0;
        r_iter_done  <= 1'b1;
        if (w_step_due) begin
          r_count_comp <= '0;
          r_q          <= w_q_next;
          r_q_step     <= 1'b1;
        end else begin
          r_count_comp <= r_count_comp + 1'b1;
        end
      end else if (bus.en_upd) begin
        // addr already points at the next row after the NN-th MAC.
        r_count_mult <= '0;
        r_count_spin <= (r_count_spin == LAST_IDX) ? '0 : r_count_spin + 1'b1;
      end else if (bus.en_mult) begin
        if (r_count_mult != LAST_IDX) begin
          r_count_mult <= r_count_mult + 1'b1;
        end
        r_addr <= (r_addr == LAST_ADDR) ? '0 : r_addr + 1'b1;
      end
    end
  end

  assign bus.count_mult = r_count_mult;
  assign bus.count_spin = r_count_spin;
  assign bus.count_comp = r_count_comp;
  assign bus.Q          = r_q;
  assign bus.addr       = r_addr;
  assign bus.q_step     = r_q_step;
  assign bus.iter_done  = r_iter_done;

  a_mult_with_upd : assert property (@(posedge clk) disable iff (rst_sys)
    !(bus.en_upd && bus.en_mult && !bus.rst_iter && !bus.rst_ini))
    else $warning("anneal_counter: en_mult dropped, en_upd took priority");

  // An en_mult at the last index is legal only as the NN-th MAC of the spin.
  a_extra_mac : assert property (@(posedge clk) disable iff (rst_sys)
    (bus.en_mult && !bus.en_upd && !bus.rst_iter && !bus.rst_ini && r_count_mult == LAST_IDX)
    |-> (int'(r_addr) == int'(r_count_spin) * NN + NN - 1))
    else $warning("anneal_counter: en_mult beyond NN MACs in one spin");

endmodule

// File: tb/tb_anneal_counter.sv
// Bench for anneal_counter: directed scenarios plus protocol-shaped random
// scheduling, checked every cycle against a plain-arithmetic model.
module tb_anneal_counter;

  localparam int NN = 4;
  localparam int TW = 8;
  localparam int AW = 4;

  logic clk;
  logic rst_sys;

  int checks = 0;
  int errors = 0;
  bit chk_en = 0;

  int m_mult, m_spin, m_comp, m_q, m_addr, m_qs, m_id;

  anneal_counter_if #(.NN(NN), .TEM_WIDTH(TW), .AW(AW)) bus ();

  anneal_counter #(.NN(NN), .TEM_WIDTH(TW), .AW(AW)) dut (
    .clk    (clk),
    .rst_sys(rst_sys),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic void model_zero();
    m_mult = 0; m_spin = 0; m_comp = 0; m_q = 0; m_addr = 0; m_qs = 0; m_id = 0;
  endfunction

  // Expected state after one clock edge, straight from the strobe rules.
  function automatic void model_apply(input bit ini, input bit iter, input bit upd, input bit mult);
    int te;
    int s;
    m_qs = 0;
    m_id = 0;
    if (ini) begin
      m_mult = 0; m_spin = 0; m_comp = 0; m_addr = 0;
      m_q = int'(bus.Qmin);
    end else if (iter) begin
      m_mult = 0; m_spin = 0; m_addr = 0;
      te = (bus.tau == 0) ? 1 : int'(bus.tau);
      if (m_comp == te - 1) begin
        m_comp = 0;
        s = m_q + int'(bus.Qstep);
        m_q = (s > int'(bus.Qmax)) ? int'(bus.Qmax) : s;
        m_qs = 1;
      end else begin
        m_comp = (m_comp + 1) % 256;
      end
      m_id = 1;
    end else if (upd) begin
      m_mult = 0;
      m_spin = (m_spin + 1) % NN;
    end else if (mult) begin
      m_mult = (m_mult + 1 > NN - 1) ? NN - 1 : m_mult + 1;
      m_addr = (m_addr + 1) % (NN * NN);
    end
  endfunction

  task automatic cyc(input bit ini, input bit iter, input bit upd, input bit mult);
    bus.rst_ini  = ini;
    bus.rst_iter = iter;
    bus.en_upd   = upd;
    bus.en_mult  = mult;
    @(posedge clk);
    #1;
    model_apply(ini, iter, upd, mult);
  endtask

  task automatic set_par(input int t, input int qmin, input int qstep, input int qmax);
    bus.tau   = 8'(t);
    bus.Qmin  = 8'(qmin);
    bus.Qstep = 8'(qstep);
    bus.Qmax  = 8'(qmax);
  endtask

  task automatic one_spin(input bit rnd_gaps);
    int m;
    m = 0;
    while (m < NN) begin
      if (rnd_gaps && $urandom_range(3) == 0) begin
        cyc(0, 0, 0, 0);
      end else begin
        cyc(0, 0, 0, 1);
        m++;
      end
    end
    cyc(0, 0, 1, 0);
  endtask

  // Single compare process: every output against the model each cycle.
  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        chk("count_mult", int'(bus.count_mult), m_mult);
        chk("count_spin", int'(bus.count_spin), m_spin);
        chk("count_comp", int'(bus.count_comp), m_comp);
        chk("Q", int'(bus.Q), m_q);
        chk("addr", int'(bus.addr), m_addr);
        chk("q_step", int'(bus.q_step), m_qs);
        chk("iter_done", int'(bus.iter_done), m_id);
      end
    end
  end

  initial begin
    int qexp[4]  = '{-4, -1, -1, 2};
    int qsexp[4] = '{0, 1, 0, 1};

    rst_sys = 1'b1;
    bus.rst_ini = 0; bus.rst_iter = 0; bus.en_upd = 0; bus.en_mult = 0;
    set_par(2, -4, 3, 5);
    model_zero();
    #3;
    chk("rst_count_mult", int'(bus.count_mult), 0);
    chk("rst_count_comp", int'(bus.count_comp), 0);
    chk("rst_Q", int'(bus.Q), 0);
    chk("rst_addr", int'(bus.addr), 0);
    chk("rst_q_step", int'(bus.q_step), 0);
    chk("rst_iter_done", int'(bus.iter_done), 0);
    @(negedge clk);
    rst_sys = 1'b0;
    chk_en = 1;

    // Main sweep: tau=2, Q -4 -> -1 -> 2.
    cyc(1, 0, 0, 0);
    chk("init_Q", int'(bus.Q), -4);
    for (int it = 0; it < 4; it++) begin
      for (int s = 0; s < NN; s++) one_spin(0);
      chk("addr_wrap", int'(bus.addr), 0);
      cyc(0, 1, 0, 0);
      chk("q_seq", int'(bus.Q), qexp[it]);
      chk("q_step_seq", int'(bus.q_step), qsexp[it]);
      chk("iter_done_seq", int'(bus.iter_done), 1);
    end

    // Q clamps at Qmax instead of wrapping.
    set_par(1, 3, 4, 5);
    cyc(1, 0, 0, 0);
    cyc(0, 1, 0, 0);
    chk("sat_Q1", int'(bus.Q), 5);
    cyc(0, 1, 0, 0);
    chk("sat_Q2", int'(bus.Q), 5);

    // tau=0 behaves as tau=1.
    set_par(0, 0, 1, 100);
    cyc(1, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      cyc(0, 1, 0, 0);
      chk("tau0_comp", int'(bus.count_comp), 0);
      chk("tau0_Q", int'(bus.Q), i + 1);
    end

    // rst_ini overrides a simultaneous rst_iter.
    set_par(3, -10, 2, 20);
    cyc(1, 0, 0, 0);
    cyc(0, 1, 0, 0);
    cyc(0, 1, 0, 0);
    cyc(1, 1, 0, 0);
    chk("ini_iter_Q", int'(bus.Q), -10);
    chk("ini_iter_done", int'(bus.iter_done), 0);
    chk("ini_iter_comp", int'(bus.count_comp), 0);

    // Asynchronous reset mid-spin.
    cyc(1, 0, 0, 0);
    one_spin(0);
    cyc(0, 0, 0, 1);
    cyc(0, 0, 0, 1);
    chk("mid_mult", int'(bus.count_mult), 2);
    chk("mid_spin", int'(bus.count_spin), 1);
    #1;
    bus.en_mult = 0;
    rst_sys = 1'b1;
    model_zero();
    #1;
    chk("arst_mult", int'(bus.count_mult), 0);
    chk("arst_spin", int'(bus.count_spin), 0);
    chk("arst_Q", int'(bus.Q), 0);
    chk("arst_addr", int'(bus.addr), 0);
    @(negedge clk);
    rst_sys = 1'b0;

    // en_upd wins over a simultaneous en_mult.
    set_par(2, 0, 1, 10);
    cyc(1, 0, 0, 0);
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 1);
    cyc(0, 0, 1, 1);
    chk("both_mult", int'(bus.count_mult), 0);
    chk("both_spin", int'(bus.count_spin), 1);
    chk("both_addr", int'(bus.addr), 3);

    // Random scheduling following the per-spin protocol.
    for (int r = 0; r < 40; r++) begin
      if (r % 8 == 0) begin
        set_par($urandom_range(3), int'($urandom_range(255)) - 128,
                $urandom_range(40), int'($urandom_range(255)) - 128);
        cyc(1, 0, 0, 0);
      end
      for (int s = 0; s < NN; s++) one_spin(1);
      if ($urandom_range(3) == 0) cyc(0, 0, 0, 0);
      cyc(0, 1, 1'($urandom_range(1)), 1'($urandom_range(1)));
    end

    chk_en = 0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
